// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared sample/effect types and the saturating mix helper
package audio_pkg;

    typedef logic [7:0] sample_t;
    typedef logic [1:0] effect_t;

    localparam sample_t SILENCE = 8'd128;

    typedef enum logic {
        ST_IDLE,
        ST_PLAY
    } fx_state_e;

    // Offset-binary mix: both terms carry a +128 bias, so one bias is removed before clamping.
    function automatic sample_t mix_sat(input sample_t song, input sample_t fx);
        logic signed [9:0] sum;
        sum = $signed({2'b00, song}) + $signed({2'b00, fx}) - 10'sd128;
        if (sum < 10'sd0) begin
            return 8'd0;
        end else if (sum > 10'sd255) begin
            return 8'd255;
        end else begin
            return sum[7:0];
        end
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// rtl/sample_tick_gen.sv - free-running sample-rate counter with a one-cycle tick
module sample_tick_gen #(
    parameter int CLKS_PER_SAMPLE = 12500
) (
    input  logic clk_100mhz,
    input  logic rst_in,
    output logic tick_out
);

    localparam int CW = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_SAMPLE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_out = (cnt_q == LAST);

    always_comb begin
        cnt_d = tick_out ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk_100mhz) begin
        if (rst_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/audio_sample_mixer.sv
// rtl/audio_sample_mixer.sv - paces song/effect FIFO reads, sequences effects, mixes with saturation
module audio_sample_mixer
    import audio_pkg::*;
#(
    parameter int CLKS_PER_SAMPLE = 12500,
    parameter int EFFECT_LEN      = 4000
) (
    input  logic       clk_100mhz,
    input  logic       rst_in,
    input  logic [1:0] effect_in,
    input  logic [7:0] song_dout_in,
    input  logic       song_empty_in,
    output logic       song_rd_out,
    input  logic [7:0] fx_dout_in,
    input  logic       fx_empty_in,
    output logic       fx_rd_out,
    output logic       fx_start_out,
    output logic [1:0] fx_sel_out,
    output logic [7:0] sample_out,
    output logic       underrun_out
);

    localparam int NW = (EFFECT_LEN > 1) ? $clog2(EFFECT_LEN) : 1;
    localparam logic [NW-1:0] LAST_FX = NW'(EFFECT_LEN - 1);

    logic      tick;
    logic      song_rd;
    logic      fx_rd;

    fx_state_e state_q,    state_d;
    logic [NW-1:0] fx_cnt_q, fx_cnt_d;
    effect_t   fx_sel_q,   fx_sel_d;
    logic      fx_start_q, fx_start_d;
    logic      song_vld_q, song_vld_d;
    logic      fx_vld_q,   fx_vld_d;
    logic      mix_q,      mix_d;
    sample_t   sample_q,   sample_d;
    logic      underrun_q, underrun_d;

    sample_tick_gen #(
        .CLKS_PER_SAMPLE(CLKS_PER_SAMPLE)
    ) u_tick (
        .clk_100mhz(clk_100mhz),
        .rst_in    (rst_in),
        .tick_out  (tick)
    );

    always_comb begin
        state_d    = state_q;
        fx_cnt_d   = fx_cnt_q;
        fx_sel_d   = fx_sel_q;
        fx_start_d = 1'b0;
        fx_rd      = 1'b0;
        song_rd    = tick && !song_empty_in && !rst_in;

        case (state_q)
            ST_IDLE: begin
                if (effect_in != 2'd0) begin
                    fx_sel_d   = effect_in;
                    fx_start_d = 1'b1;
                    fx_cnt_d   = '0;
                    state_d    = ST_PLAY;
                end else begin
                    fx_rd = !fx_empty_in;
                end
            end
            ST_PLAY: begin
                if (tick) begin
                    fx_rd    = !fx_empty_in;
                    fx_cnt_d = fx_cnt_q + NW'(1);
                    if (fx_cnt_q == LAST_FX) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        fx_rd = fx_rd && !rst_in;

        // Only PLAY-tick pops feed the mix; IDLE flush data is discarded.
        song_vld_d = song_rd;
        fx_vld_d   = fx_rd && tick && (state_q == ST_PLAY);
        mix_d      = tick;
        underrun_d = underrun_q | (tick & song_empty_in);

        sample_d = sample_q;
        if (mix_q) begin
            sample_d = mix_sat(song_vld_q ? song_dout_in : SILENCE,
                               fx_vld_q   ? fx_dout_in   : SILENCE);
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            fx_cnt_q   <= '0;
            fx_sel_q   <= 2'd0;
            fx_start_q <= 1'b0;
            song_vld_q <= 1'b0;
            fx_vld_q   <= 1'b0;
            mix_q      <= 1'b0;
            sample_q   <= SILENCE;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fx_cnt_q   <= fx_cnt_d;
            fx_sel_q   <= fx_sel_d;
            fx_start_q <= fx_start_d;
            song_vld_q <= song_vld_d;
            fx_vld_q   <= fx_vld_d;
            mix_q      <= mix_d;
            sample_q   <= sample_d;
            underrun_q <= underrun_d;
        end
    end

    assign song_rd_out  = song_rd;
    assign fx_rd_out    = fx_rd;
    assign fx_start_out = fx_start_q;
    assign fx_sel_out   = fx_sel_q;
    assign sample_out   = sample_q;
    assign underrun_out = underrun_q;

endmodule

// File: tb/tb_audio_sample_mixer.sv
// tb/tb_audio_sample_mixer.sv - directed-vector bench for audio_sample_mixer
module tb_audio_sample_mixer;

    logic       clk;
    logic       rst_in;
    logic [1:0] effect_in;
    logic [7:0] song_dout;
    logic       song_empty;
    logic       song_rd;
    logic [7:0] fx_dout;
    logic       fx_empty;
    logic       fx_rd;
    logic       fx_start;
    logic [1:0] fx_sel;
    logic [7:0] sample;
    logic       underrun;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    logic [7:0] song_mem [0:63];
    logic [7:0] fx_mem   [0:63];
    int song_wr = 0;
    int song_rp = 0;
    int fx_wr   = 0;
    int fx_rp   = 0;
    int fx_pops = 0;
    int pops0;

    audio_sample_mixer #(
        .CLKS_PER_SAMPLE(10),
        .EFFECT_LEN     (3)
    ) dut (
        .clk_100mhz   (clk),
        .rst_in       (rst_in),
        .effect_in    (effect_in),
        .song_dout_in (song_dout),
        .song_empty_in(song_empty),
        .song_rd_out  (song_rd),
        .fx_dout_in   (fx_dout),
        .fx_empty_in  (fx_empty),
        .fx_rd_out    (fx_rd),
        .fx_start_out (fx_start),
        .fx_sel_out   (fx_sel),
        .sample_out   (sample),
        .underrun_out (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign song_empty = (song_wr == song_rp);
    assign fx_empty   = (fx_wr == fx_rp);

    // Standard (non-FWFT) FIFO models: dout appears the cycle after rd_en.
    always @(posedge clk) begin
        if (song_rd) begin
            song_dout <= song_mem[song_rp];
            song_rp   <= song_rp + 1;
        end
        if (fx_rd) begin
            fx_dout <= fx_mem[fx_rp];
            fx_rp   <= fx_rp + 1;
            fx_pops <= fx_pops + 1;
        end
        if (rst_in) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic push_song(input logic [7:0] v);
        song_mem[song_wr] = v;
        song_wr++;
    endtask

    task automatic push_fx(input logic [7:0] v);
        fx_mem[fx_wr] = v;
        fx_wr++;
    endtask

    task automatic at_cyc(input int n);
        int guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (cyc != n && guard < 2000);
        if (cyc != n) check("timeout", cyc, n);
    endtask

    initial begin
        rst_in    = 1'b1;
        effect_in = 2'd0;
        song_dout = 8'd0;
        fx_dout   = 8'd0;
        push_song(8'd50);
        push_song(8'd60);
        push_song(8'd70);
        repeat (3) @(negedge clk);
        check("rst_sample",   sample,   8'd128);
        check("rst_underrun", underrun, 1'b0);
        check("rst_fx_start", fx_start, 1'b0);
        check("rst_fx_sel",   fx_sel,   2'd0);
        check("rst_song_rd",  song_rd,  1'b0);
        rst_in = 1'b0;

        at_cyc(9);  check("song_rd_tick", song_rd, 1'b1);
        at_cyc(10); check("song_rd_once", song_rd, 1'b0);
        at_cyc(11); check("song_50", sample, 8'd50);
        at_cyc(21); check("song_60", sample, 8'd60);
        at_cyc(31); check("song_70", sample, 8'd70);
                    check("no_underrun", underrun, 1'b0);
        at_cyc(39); check("no_rd_empty", song_rd, 1'b0);
        at_cyc(41); check("underrun_silence", sample, 8'd128);
                    check("underrun_set", underrun, 1'b1);

        at_cyc(42); effect_in = 2'd2;
        at_cyc(43); effect_in = 2'd0;
                    check("fx_start_pulse", fx_start, 1'b1);
                    check("fx_sel_2", fx_sel, 2'd2);
                    push_song(8'd100); push_song(8'd250); push_song(8'd10);
                    push_fx(8'd200);   push_fx(8'd250);   push_fx(8'd20);
        at_cyc(44); check("fx_start_once", fx_start, 1'b0);
        at_cyc(51); check("mix_172", sample, 8'd172);
        at_cyc(59); check("fx_rd_tick", fx_rd, 1'b1);
        at_cyc(60); check("fx_rd_once", fx_rd, 1'b0);
        at_cyc(61); check("sat_high", sample, 8'd255);
        at_cyc(71); check("sat_low", sample, 8'd0);
        at_cyc(75); check("fx_pops_3", fx_pops, 3);
                    check("underrun_sticky", underrun, 1'b1);

        at_cyc(80);  effect_in = 2'd1;
        at_cyc(81);  check("b2b_start1", fx_start, 1'b1);
                     check("fx_sel_1", fx_sel, 2'd1);
        at_cyc(110); check("b2b_gap", fx_start, 1'b0);
        at_cyc(111); check("b2b_start2", fx_start, 1'b1);
        at_cyc(112); effect_in = 2'd0;

        at_cyc(144); pops0 = fx_pops;
                     for (int i = 0; i < 5; i++) push_fx(8'(i + 1));
        at_cyc(145); check("flush_first", fx_rd, 1'b1);
        at_cyc(148); check("flush_last", fx_rd, 1'b1);
        at_cyc(149); check("flush_done", fx_rd, 1'b0);
                     check("flush_count", fx_pops - pops0, 5);

        at_cyc(150); effect_in = 2'd3;
                     push_song(8'd90);
        at_cyc(151); effect_in = 2'd0;
                     check("fx_sel_3", fx_sel, 2'd3);
                     push_fx(8'd200);
        at_cyc(160); rst_in = 1'b1;
        @(negedge clk);
        check("midrst_sample",   sample,   8'd128);
        check("midrst_underrun", underrun, 1'b0);
        check("midrst_fx_start", fx_start, 1'b0);
        check("midrst_fx_sel",   fx_sel,   2'd0);
        check("midrst_song_rd",  song_rd,  1'b0);
        check("midrst_fx_rd",    fx_rd,    1'b0);
        push_song(8'd77);
        rst_in = 1'b0;

        at_cyc(9);  check("resume_rd", song_rd, 1'b1);
        at_cyc(11); check("resume_77", sample, 8'd77);
                    check("resume_underrun", underrun, 1'b0);
                    check("resume_fx_sel", fx_sel, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
